axi_lite_mmio_arbiter: RTL and testbench
========================================

// Module: axi_lite_mmio_arbiter
// PURPOSE
//  Shares the single AXI4-Lite slave port of the MMIO controller between NUM_M AXI4-Lite masters (CPU, debug, DMA).
//  Round-robin grant, one transaction in flight; forwards the granted master's channels and returns responses to it.
//  Requests outside the MMIO window are answered locally with DECERR and never forwarded downstream.
// PARAMETERS
//  NUM_M    2        number of upstream masters (2..8); master i uses slice i of every packed port
//  BASE_HI  16'h4600 required addr[31:16] for MMIO window; any other value is answered locally
// PORTS
//  aclk              in   1  system clock
//  arst_n            in   1  reset, synchronous, active-low
//  S_AXI_aw*  in: addr NUM_M*32, prot NUM_M*3, valid NUM_M; out: ready NUM_M  per-master write address
//  S_AXI_w*   in: data NUM_M*32, strb NUM_M*4, valid NUM_M; out: ready NUM_M  per-master write data
//  S_AXI_b*   out: resp NUM_M*2, valid NUM_M; in: ready NUM_M                 per-master write response
//  S_AXI_ar*  in: addr NUM_M*32, prot NUM_M*3, valid NUM_M; out: ready NUM_M  per-master read address
//  S_AXI_r*   out: data NUM_M*32, resp NUM_M*2, valid NUM_M; in: ready NUM_M  per-master read data
//  M_AXI_aw*/w*/b*/ar*/r*  same fields, single channel, opposite directions    to MMIO controller slave port
//  grant             out  $clog2(NUM_M)  index of master owning the port (valid when busy=1)
//  busy              out  1  transaction in progress (state != IDLE)
// BEHAVIOUR
//  Reset (arst_n=0 at aclk edge): state IDLE; all S_*ready/valid, M_*valid/ready = 0; grant=0; busy=0;
//    last_grant = NUM_M-1 so master 0 wins first; all data/resp outputs 0. Reset mid-transaction aborts to IDLE.
//  States: IDLE, WR_FWD, WR_RESP, RD_FWD, RD_RESP, DEC_WR, DEC_RD.
//  IDLE: req[i] = S_awvalid[i] | S_arvalid[i]; pick first req at or after (last_grant+1) mod NUM_M.
//    Within the winner, write beats read when both valid. No ready asserted in IDLE. Register grant, type,
//    and in_range = (addr[31:16]==BASE_HI). Next: WR_FWD / RD_FWD, or DEC_WR / DEC_RD if !in_range.
//  WR_FWD: M_aw*/M_w* driven from granted master; S_awready[g]=M_awready and S_wready[g]=M_wready.
//    Sticky flags aw_done, w_done are set on the respective handshakes; each valid is masked off once its flag is set.
//    Both set -> WR_RESP.
//  WR_RESP: S_bvalid[g]=M_bvalid, S_bresp[g]=M_bresp, M_bready=S_bready[g]; handshake -> IDLE, last_grant<=g.
//  RD_FWD: M_ar* from granted master, S_arready[g]=M_arready; handshake -> RD_RESP.
//  RD_RESP: S_r*[g] <= M_r* combinationally, M_rready=S_rready[g]; handshake -> IDLE, last_grant<=g.
//  DEC_WR: S_awready[g]=1 until aw handshake, then S_wready[g]=1 until w handshake;
//    then S_bvalid[g]=1, bresp=2'b11 until S_bready[g]; -> IDLE.
//  DEC_RD: S_arready[g]=1 for the handshake, then S_rvalid[g]=1, rdata=0, rresp=2'b11 until S_rready[g]; -> IDLE.
//  Non-granted masters: all ready/valid = 0, data/resp = 0; their requests are held until granted (no drop).
//  Latency: request in IDLE at cycle n -> M_awvalid/M_arvalid at cycle n+1; response is zero-cycle pass-through.
//  Back-to-back: return to IDLE costs 1 cycle; minimum 1 idle cycle between downstream transactions.
//  M_awvalid and M_arvalid are never asserted together. Arbitration uses only valids sampled in IDLE.
//  Fairness: with all NUM_M masters continuously requesting, each is granted once every NUM_M transactions.
// TESTING
//  M0 write 0x4600_0104 data 0xDEADBEEF -> M_awaddr=0x4600_0104, M_wdata=0xDEADBEEF; M0 gets bvalid, bresp=00.
//  M0 and M1 both assert arvalid in the same cycle after reset -> M0 served first, then M1; grant 0 then 1.
//  Both masters keep requesting for 6 transactions -> grant sequence 0,1,0,1,0,1.
//  M1 reads 0x4700_0000 -> M_arvalid never asserted; M1 gets rvalid, rresp=11, rdata=0.
//  M0 has awvalid and arvalid together -> write forwarded first; read forwarded as next M0 transaction.
//  Arbiter in WR_FWD with aw done, w pending; arst_n=0 for 1 cycle -> next cycle IDLE, all valids=0, busy=0.
//  M0 wvalid 2 cycles before awvalid -> single downstream write; bvalid reaches M0 only.

Source files
------------

// File: rtl/axi_lite_mmio_arbiter.sv
// axi_lite_mmio_arbiter
//   Shares one AXI4-Lite slave port (the MMIO controller) between NUM_M AXI4-Lite
//   masters. Grants are round-robin, and only one transaction is in flight at a time.
//   A request whose addr[31:16] does not match BASE_HI is completed locally with
//   DECERR and never reaches the downstream port.
//
// Ports
//   aclk, arst_n          clock; synchronous active-low reset
//   S_AXI_aw*/w*/b*/ar*/r*  NUM_M upstream masters; master i owns slice i of each
//                          packed port (32-bit addr/data, 3-bit prot, 4-bit strb,
//                          2-bit resp)
//   M_AXI_aw*/w*/b*/ar*/r*  single downstream port to the MMIO controller
//   grant                  index of the master that owns the port (valid while busy)
//   busy                   a transaction is in progress

module axi_lite_mmio_arbiter #(
    parameter int          NUM_M   = 2,
    parameter logic [15:0] BASE_HI = 16'h4600
) (
    input  logic                       aclk,
    input  logic                       arst_n,

    input  logic [NUM_M*32-1:0]        S_AXI_awaddr,
    input  logic [NUM_M*3-1:0]         S_AXI_awprot,
    input  logic [NUM_M-1:0]           S_AXI_awvalid,
    output logic [NUM_M-1:0]           S_AXI_awready,
    input  logic [NUM_M*32-1:0]        S_AXI_wdata,
    input  logic [NUM_M*4-1:0]         S_AXI_wstrb,
    input  logic [NUM_M-1:0]           S_AXI_wvalid,
    output logic [NUM_M-1:0]           S_AXI_wready,
    output logic [NUM_M*2-1:0]         S_AXI_bresp,
    output logic [NUM_M-1:0]           S_AXI_bvalid,
    input  logic [NUM_M-1:0]           S_AXI_bready,
    input  logic [NUM_M*32-1:0]        S_AXI_araddr,
    input  logic [NUM_M*3-1:0]         S_AXI_arprot,
    input  logic [NUM_M-1:0]           S_AXI_arvalid,
    output logic [NUM_M-1:0]           S_AXI_arready,
    output logic [NUM_M*32-1:0]        S_AXI_rdata,
    output logic [NUM_M*2-1:0]         S_AXI_rresp,
    output logic [NUM_M-1:0]           S_AXI_rvalid,
    input  logic [NUM_M-1:0]           S_AXI_rready,

    output logic [31:0]                M_AXI_awaddr,
    output logic [2:0]                 M_AXI_awprot,
    output logic                       M_AXI_awvalid,
    input  logic                       M_AXI_awready,
    output logic [31:0]                M_AXI_wdata,
    output logic [3:0]                 M_AXI_wstrb,
    output logic                       M_AXI_wvalid,
    input  logic                       M_AXI_wready,
    input  logic [1:0]                 M_AXI_bresp,
    input  logic                       M_AXI_bvalid,
    output logic                       M_AXI_bready,
    output logic [31:0]                M_AXI_araddr,
    output logic [2:0]                 M_AXI_arprot,
    output logic                       M_AXI_arvalid,
    input  logic                       M_AXI_arready,
    input  logic [31:0]                M_AXI_rdata,
    input  logic [1:0]                 M_AXI_rresp,
    input  logic                       M_AXI_rvalid,
    output logic                       M_AXI_rready,

    output logic [$clog2(NUM_M)-1:0]   grant,
    output logic                       busy
);

    localparam int GW = $clog2(NUM_M);

    typedef enum logic [2:0] {
        IDLE, WR_FWD, WR_RESP, RD_FWD, RD_RESP, DEC_WR, DEC_RD
    } state_t;

    state_t        state, state_nx;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] win, hi_win;
    logic          win_vld, hi_vld, win_wr, win_in_range;
    logic [31:0]   win_addr;
    logic [NUM_M-1:0] req;
    logic          aw_done, w_done, ar_done;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Per-master views of the packed ports
    logic [31:0] s_awaddr [NUM_M];
    logic [2:0]  s_awprot [NUM_M];
    logic [31:0] s_wdata  [NUM_M];
    logic [3:0]  s_wstrb  [NUM_M];
    logic [31:0] s_araddr [NUM_M];
    logic [2:0]  s_arprot [NUM_M];
    logic [1:0]  s_bresp  [NUM_M];
    logic [31:0] s_rdata  [NUM_M];
    logic [1:0]  s_rresp  [NUM_M];

    for (genvar i = 0; i < NUM_M; i++) begin : g_slice
        assign s_awaddr[i] = S_AXI_awaddr[i*32 +: 32];
        assign s_awprot[i] = S_AXI_awprot[i*3 +: 3];
        assign s_wdata[i]  = S_AXI_wdata[i*32 +: 32];
        assign s_wstrb[i]  = S_AXI_wstrb[i*4 +: 4];
        assign s_araddr[i] = S_AXI_araddr[i*32 +: 32];
        assign s_arprot[i] = S_AXI_arprot[i*3 +: 3];
        assign S_AXI_bresp[i*2 +: 2]  = s_bresp[i];
        assign S_AXI_rdata[i*32 +: 32] = s_rdata[i];
        assign S_AXI_rresp[i*2 +: 2]  = s_rresp[i];
    end

    assign req  = S_AXI_awvalid | S_AXI_arvalid;
    assign busy = (state != IDLE);

    // Round-robin pick: the lowest requester above last_grant wins; if there is
    // none, wrap around to the lowest requester overall.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        hi_win  = '0;
        hi_vld  = 1'b0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req[i]) begin
                win     = GW'(i);
                win_vld = 1'b1;
            end
            if (req[i] && (GW'(i) > last_grant)) begin
                hi_win = GW'(i);
                hi_vld = 1'b1;
            end
        end
        if (hi_vld) begin
            win = hi_win;
        end
    end

    // Write takes precedence over read within the winning master
    assign win_wr       = S_AXI_awvalid[win];
    assign win_addr     = win_wr ? s_awaddr[win] : s_araddr[win];
    assign win_in_range = (win_addr[31:16] == BASE_HI);

    // Upstream handshakes of the granted master; the ready/valid terms are zero
    // in every state that does not use the channel.
    assign aw_hs = S_AXI_awvalid[grant] & S_AXI_awready[grant];
    assign w_hs  = S_AXI_wvalid[grant]  & S_AXI_wready[grant];
    assign b_hs  = S_AXI_bvalid[grant]  & S_AXI_bready[grant];
    assign ar_hs = S_AXI_arvalid[grant] & S_AXI_arready[grant];
    assign r_hs  = S_AXI_rvalid[grant]  & S_AXI_rready[grant];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    if (win_wr) begin
                        state_nx = win_in_range ? WR_FWD : DEC_WR;
                    end else begin
                        state_nx = win_in_range ? RD_FWD : DEC_RD;
                    end
                end
            end
            WR_FWD:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WR_RESP;
            WR_RESP: if (b_hs) state_nx = IDLE;
            RD_FWD:  if (ar_hs) state_nx = RD_RESP;
            RD_RESP: if (r_hs) state_nx = IDLE;
            DEC_WR:  if (b_hs) state_nx = IDLE;
            DEC_RD:  if (r_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_M - 1);
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ar_done    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                ar_done <= 1'b0;
                if (win_vld) begin
                    grant <= win;
                end
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
                if (ar_hs) ar_done <= 1'b1;
                if (state_nx == IDLE) begin
                    last_grant <= grant;
                end
            end
        end
    end

    // Channel steering. Everything not owned by the granted master in the
    // current state stays at zero.
    always_comb begin
        S_AXI_awready = '0;
        S_AXI_wready  = '0;
        S_AXI_bvalid  = '0;
        S_AXI_arready = '0;
        S_AXI_rvalid  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            s_bresp[i] = '0;
            s_rdata[i] = '0;
            s_rresp[i] = '0;
        end
        M_AXI_awaddr  = '0;
        M_AXI_awprot  = '0;
        M_AXI_awvalid = 1'b0;
        M_AXI_wdata   = '0;
        M_AXI_wstrb   = '0;
        M_AXI_wvalid  = 1'b0;
        M_AXI_bready  = 1'b0;
        M_AXI_araddr  = '0;
        M_AXI_arprot  = '0;
        M_AXI_arvalid = 1'b0;
        M_AXI_rready  = 1'b0;

        unique case (state)
            WR_FWD: begin
                // A channel that has already handshaken is masked so a master
                // presenting its next beat early cannot be accepted twice.
                M_AXI_awaddr         = s_awaddr[grant];
                M_AXI_awprot         = s_awprot[grant];
                M_AXI_awvalid        = S_AXI_awvalid[grant] & ~aw_done;
                M_AXI_wdata          = s_wdata[grant];
                M_AXI_wstrb          = s_wstrb[grant];
                M_AXI_wvalid         = S_AXI_wvalid[grant] & ~w_done;
                S_AXI_awready[grant] = M_AXI_awready & ~aw_done;
                S_AXI_wready[grant]  = M_AXI_wready & ~w_done;
            end
            WR_RESP: begin
                S_AXI_bvalid[grant] = M_AXI_bvalid;
                s_bresp[grant]      = M_AXI_bresp;
                M_AXI_bready        = S_AXI_bready[grant];
            end
            RD_FWD: begin
                M_AXI_araddr         = s_araddr[grant];
                M_AXI_arprot         = s_arprot[grant];
                M_AXI_arvalid        = S_AXI_arvalid[grant];
                S_AXI_arready[grant] = M_AXI_arready;
            end
            RD_RESP: begin
                S_AXI_rvalid[grant] = M_AXI_rvalid;
                s_rdata[grant]      = M_AXI_rdata;
                s_rresp[grant]      = M_AXI_rresp;
                M_AXI_rready        = S_AXI_rready[grant];
            end
            DEC_WR: begin
                // Address, then data, then the DECERR response
                if (!aw_done) begin
                    S_AXI_awready[grant] = 1'b1;
                end else if (!w_done) begin
                    S_AXI_wready[grant] = 1'b1;
                end else begin
                    S_AXI_bvalid[grant] = 1'b1;
                    s_bresp[grant]      = 2'b11;
                end
            end
            DEC_RD: begin
                if (!ar_done) begin
                    S_AXI_arready[grant] = 1'b1;
                end else begin
                    S_AXI_rvalid[grant] = 1'b1;
                    s_rresp[grant]      = 2'b11;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_mmio_arbiter.sv
// tb_axi_lite_mmio_arbiter
//   Two-master bench for axi_lite_mmio_arbiter. A behavioural MMIO slave sits on
//   the downstream port (always ready, OKAY responses, read data = addr ^ RD_XOR)
//   and checks every downstream transaction against a queue of expected ones.

module tb_axi_lite_mmio_arbiter;

    localparam int          NUM_M  = 2;
    localparam int          MW     = $clog2(NUM_M);
    localparam logic [31:0] RD_XOR = 32'hA5A5_A5A5;
    localparam int          MAXW   = 64;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    // Upstream (master side)
    logic [31:0] awaddr_a [NUM_M];
    logic [31:0] wdata_a  [NUM_M];
    logic [31:0] araddr_a [NUM_M];
    logic [NUM_M*32-1:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [NUM_M*3-1:0]  s_awprot, s_arprot;
    logic [NUM_M*4-1:0]  s_wstrb;
    logic [NUM_M*2-1:0]  s_bresp, s_rresp;
    logic [NUM_M-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [NUM_M-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]          bresp_v [NUM_M];
    logic [31:0]         rdata_v [NUM_M];
    logic [1:0]          rresp_v [NUM_M];

    for (genvar i = 0; i < NUM_M; i++) begin : g_tb_slice
        assign s_awaddr[i*32 +: 32] = awaddr_a[i];
        assign s_wdata[i*32 +: 32]  = wdata_a[i];
        assign s_araddr[i*32 +: 32] = araddr_a[i];
        assign bresp_v[i] = s_bresp[i*2 +: 2];
        assign rdata_v[i] = s_rdata[i*32 +: 32];
        assign rresp_v[i] = s_rresp[i*2 +: 2];
    end
    assign s_awprot = '0;
    assign s_arprot = '0;
    assign s_wstrb  = '1;

    // Downstream (MMIO slave side)
    logic [31:0] dm_awaddr, dm_wdata, dm_araddr, dm_rdata;
    logic [2:0]  dm_awprot, dm_arprot;
    logic [3:0]  dm_wstrb;
    logic [1:0]  dm_bresp, dm_rresp;
    logic        dm_awvalid, dm_wvalid, dm_bready, dm_arvalid, dm_rready;
    logic        dm_awready, dm_wready, dm_bvalid, dm_arready, dm_rvalid;
    logic [MW-1:0] grant;
    logic        busy;

    axi_lite_mmio_arbiter #(.NUM_M(NUM_M), .BASE_HI(16'h4600)) dut (
        .aclk(clk), .arst_n(arst_n),
        .S_AXI_awaddr(s_awaddr), .S_AXI_awprot(s_awprot), .S_AXI_awvalid(s_awvalid), .S_AXI_awready(s_awready),
        .S_AXI_wdata(s_wdata), .S_AXI_wstrb(s_wstrb), .S_AXI_wvalid(s_wvalid), .S_AXI_wready(s_wready),
        .S_AXI_bresp(s_bresp), .S_AXI_bvalid(s_bvalid), .S_AXI_bready(s_bready),
        .S_AXI_araddr(s_araddr), .S_AXI_arprot(s_arprot), .S_AXI_arvalid(s_arvalid), .S_AXI_arready(s_arready),
        .S_AXI_rdata(s_rdata), .S_AXI_rresp(s_rresp), .S_AXI_rvalid(s_rvalid), .S_AXI_rready(s_rready),
        .M_AXI_awaddr(dm_awaddr), .M_AXI_awprot(dm_awprot), .M_AXI_awvalid(dm_awvalid), .M_AXI_awready(dm_awready),
        .M_AXI_wdata(dm_wdata), .M_AXI_wstrb(dm_wstrb), .M_AXI_wvalid(dm_wvalid), .M_AXI_wready(dm_wready),
        .M_AXI_bresp(dm_bresp), .M_AXI_bvalid(dm_bvalid), .M_AXI_bready(dm_bready),
        .M_AXI_araddr(dm_araddr), .M_AXI_arprot(dm_arprot), .M_AXI_arvalid(dm_arvalid), .M_AXI_arready(dm_arready),
        .M_AXI_rdata(dm_rdata), .M_AXI_rresp(dm_rresp), .M_AXI_rvalid(dm_rvalid), .M_AXI_rready(dm_rready),
        .grant(grant), .busy(busy)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: got no handshake within %0d cycles, expected one", name, MAXW);
    endtask

    // Expected downstream transactions, pushed by the stimulus
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } ds_t;
    ds_t sb_q[$];

    task automatic sb_check(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        ds_t e;
        if (sb_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL ds_unexpected: got downstream %s at %h, expected none", wr ? "write" : "read", addr);
        end else begin
            e = sb_q.pop_front();
            chk("ds_is_write", 32'(wr), 32'(e.wr));
            chk("ds_addr", addr, e.addr);
            if (e.wr) chk("ds_wdata", data, e.data);
        end
    endtask

    // Behavioural MMIO slave
    int wr_done_cnt = 0;
    assign dm_awready = 1'b1;
    assign dm_arready = 1'b1;

    initial begin
        bit awhs, whs, arhs, bhs, rhs, rst_seen, got_aw, got_w;
        logic [31:0] cap_aw, cap_w, cap_ar;
        got_aw = 0; got_w = 0;
        cap_aw = '0; cap_w = '0; cap_ar = '0;
        dm_bvalid = 0; dm_bresp = 2'b00; dm_rvalid = 0; dm_rdata = '0; dm_rresp = 2'b00;
        forever begin
            @(negedge clk);
            awhs = dm_awvalid & dm_awready;
            whs  = dm_wvalid & dm_wready;
            arhs = dm_arvalid & dm_arready;
            bhs  = dm_bvalid & dm_bready;
            rhs  = dm_rvalid & dm_rready;
            rst_seen = !arst_n;
            if (awhs) cap_aw = dm_awaddr;
            if (whs)  cap_w  = dm_wdata;
            if (arhs) cap_ar = dm_araddr;
            @(posedge clk);
            #1;
            if (rst_seen) begin
                got_aw = 0; got_w = 0;
                dm_bvalid = 0; dm_rvalid = 0; dm_rdata = '0;
            end else begin
                if (bhs) dm_bvalid = 0;
                if (rhs) begin dm_rvalid = 0; dm_rdata = '0; end
                if (awhs) got_aw = 1;
                if (whs)  got_w  = 1;
                if (got_aw && got_w) begin
                    sb_check(1'b1, cap_aw, cap_w);
                    wr_done_cnt++;
                    got_aw = 0; got_w = 0;
                    dm_bvalid = 1; dm_bresp = 2'b00;
                end
                if (arhs) begin
                    sb_check(1'b0, cap_ar, '0);
                    dm_rvalid = 1; dm_rresp = 2'b00; dm_rdata = cap_ar ^ RD_XOR;
                end
            end
        end
    end

    // Activity monitor
    int aw_cnt = 0, ar_cnt = 0, b1_cnt = 0, both_cnt = 0;
    logic [MW-1:0] grant_q[$];
    initial begin
        bit busy_d;
        busy_d = 0;
        forever begin
            @(negedge clk);
            if (dm_awvalid) aw_cnt++;
            if (dm_arvalid) ar_cnt++;
            if (dm_awvalid && dm_arvalid) both_cnt++;
            if (s_bvalid[1]) b1_cnt++;
            if (busy && !busy_d) grant_q.push_back(grant);
            busy_d = busy;
        end
    end

    task automatic do_write(input logic [MW-1:0] m, input logic [31:0] addr, input logic [31:0] data,
                            input bit w_lead, output logic [1:0] resp);
        int n, lead;
        bit aw_pend, w_pend, awhs, whs, got;
        resp = 2'bxx;
        awaddr_a[m] = addr;
        wdata_a[m]  = data;
        lead = w_lead ? 2 : 0;
        s_wvalid[m]  = 1'b1;
        s_awvalid[m] = (lead == 0);
        aw_pend = 1; w_pend = 1; n = 0;
        while ((aw_pend || w_pend) && n < MAXW) begin
            @(negedge clk);
            awhs = s_awvalid[m] & s_awready[m];
            whs  = s_wvalid[m] & s_wready[m];
            @(posedge clk);
            #1;
            n++;
            if (awhs) begin s_awvalid[m] = 1'b0; aw_pend = 0; end
            if (whs)  begin s_wvalid[m]  = 1'b0; w_pend  = 0; end
            if (lead > 0) begin
                lead--;
                if (lead == 0) s_awvalid[m] = 1'b1;
            end
        end
        if (aw_pend || w_pend) begin
            s_awvalid[m] = 1'b0;
            s_wvalid[m]  = 1'b0;
            fail_timeout("write_addr_data");
            return;
        end
        s_bready[m] = 1'b1;
        got = 0; n = 0;
        while (!got && n < MAXW) begin
            @(negedge clk);
            if (s_bvalid[m]) begin got = 1; resp = bresp_v[m]; end
            @(posedge clk);
            #1;
            n++;
        end
        s_bready[m] = 1'b0;
        if (!got) fail_timeout("write_resp");
    endtask

    task automatic do_read(input logic [MW-1:0] m, input logic [31:0] addr,
                           output logic [31:0] data, output logic [1:0] resp);
        int n;
        bit hs, got;
        data = 'x;
        resp = 2'bxx;
        araddr_a[m]  = addr;
        s_arvalid[m] = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < MAXW) begin
            @(negedge clk);
            hs = s_arready[m];
            @(posedge clk);
            #1;
            n++;
        end
        s_arvalid[m] = 1'b0;
        if (!hs) begin
            fail_timeout("read_addr");
            return;
        end
        s_rready[m] = 1'b1;
        got = 0; n = 0;
        while (!got && n < MAXW) begin
            @(negedge clk);
            if (s_rvalid[m]) begin got = 1; data = rdata_v[m]; resp = rresp_v[m]; end
            @(posedge clk);
            #1;
            n++;
        end
        s_rready[m] = 1'b0;
        if (!got) fail_timeout("read_data");
    endtask

    task automatic clear_masters();
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
        for (int i = 0; i < NUM_M; i++) begin
            awaddr_a[i] = '0; wdata_a[i] = '0; araddr_a[i] = '0;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        clear_masters();
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        grant_q.delete();
    endtask

    typedef struct {
        logic [MW-1:0] m;
        bit            wr;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [1:0]    exp_resp;
        bit            exp_fwd;
        logic [31:0]   exp_rdata;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected one");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[8];
        logic [31:0] rd, rd0, rd1;
        logic [1:0]  rs, rs0, rs1;
        int aw0, ar0, b10, wc0;
        int glog[6];

        vt[0] = '{1'b0, 1'b1, 32'h4600_0104, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'h0};
        vt[1] = '{1'b0, 1'b0, 32'h4600_0104, 32'h0,         2'b00, 1'b1, 32'h4600_0104 ^ RD_XOR};
        vt[2] = '{1'b1, 1'b1, 32'h4600_FFFC, 32'h1234_5678, 2'b00, 1'b1, 32'h0};
        vt[3] = '{1'b1, 1'b0, 32'h4700_0000, 32'h0,         2'b11, 1'b0, 32'h0};
        vt[4] = '{1'b0, 1'b1, 32'h4601_0000, 32'h5555_AAAA, 2'b11, 1'b0, 32'h0};
        vt[5] = '{1'b1, 1'b0, 32'h45FF_FFFC, 32'h0,         2'b11, 1'b0, 32'h0};
        vt[6] = '{1'b0, 1'b0, 32'h4600_0000, 32'h0,         2'b00, 1'b1, 32'h4600_0000 ^ RD_XOR};
        vt[7] = '{1'b1, 1'b1, 32'h4600_0008, 32'h0000_0000, 2'b00, 1'b1, 32'h0};

        clear_masters();
        dm_wready = 1'b1;
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_m_awvalid", 32'(dm_awvalid), 0);
        chk("rst_m_arvalid", 32'(dm_arvalid), 0);
        chk("rst_m_wvalid", 32'(dm_wvalid), 0);
        chk("rst_s_valids", 32'({s_bvalid, s_rvalid}), 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Single-master vectors, including window boundaries and DECERR
        for (int i = 0; i < 8; i++) begin
            aw0 = aw_cnt;
            ar0 = ar_cnt;
            if (vt[i].exp_fwd) sb_q.push_back('{vt[i].wr, vt[i].addr, vt[i].data});
            if (vt[i].wr) begin
                do_write(vt[i].m, vt[i].addr, vt[i].data, 1'b0, rs);
                chk($sformatf("v%0d_bresp", i), 32'(rs), 32'(vt[i].exp_resp));
            end else begin
                do_read(vt[i].m, vt[i].addr, rd, rs);
                chk($sformatf("v%0d_rresp", i), 32'(rs), 32'(vt[i].exp_resp));
                chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
            end
            if (!vt[i].exp_fwd) begin
                chk($sformatf("v%0d_no_m_aw", i), 32'(aw_cnt - aw0), 0);
                chk($sformatf("v%0d_no_m_ar", i), 32'(ar_cnt - ar0), 0);
            end
            chk($sformatf("v%0d_sb_drained", i), 32'(sb_q.size()), 0);
        end

        // Simultaneous reads after reset: M0 first, then M1
        reset_dut();
        sb_q.push_back('{1'b0, 32'h4600_0020, 32'h0});
        sb_q.push_back('{1'b0, 32'h4600_0030, 32'h0});
        fork
            do_read(1'b0, 32'h4600_0020, rd0, rs0);
            do_read(1'b1, 32'h4600_0030, rd1, rs1);
        join
        chk("sim_rd0", rd0, 32'h4600_0020 ^ RD_XOR);
        chk("sim_rd1", rd1, 32'h4600_0030 ^ RD_XOR);
        for (int k = 0; k < 6; k++) glog[k] = -1;
        for (int k = 0; k < grant_q.size() && k < 6; k++) glog[k] = int'(grant_q[k]);
        chk("sim_grant_count", 32'(grant_q.size()), 2);
        chk("sim_grant0", 32'(glog[0]), 0);
        chk("sim_grant1", 32'(glog[1]), 1);

        // Fairness with both masters continuously requesting
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back('{1'b0, 32'h4600_1000 + 32'(k*4), 32'h0});
            sb_q.push_back('{1'b0, 32'h4600_2000 + 32'(k*4), 32'h0});
        end
        fork
            begin
                logic [31:0] d;
                logic [1:0]  r;
                for (int k = 0; k < 3; k++) begin
                    do_read(1'b0, 32'h4600_1000 + 32'(k*4), d, r);
                    chk("rr_m0_rdata", d, (32'h4600_1000 + 32'(k*4)) ^ RD_XOR);
                end
            end
            begin
                logic [31:0] d;
                logic [1:0]  r;
                for (int k = 0; k < 3; k++) begin
                    do_read(1'b1, 32'h4600_2000 + 32'(k*4), d, r);
                    chk("rr_m1_rdata", d, (32'h4600_2000 + 32'(k*4)) ^ RD_XOR);
                end
            end
        join
        for (int k = 0; k < 6; k++) glog[k] = -1;
        for (int k = 0; k < grant_q.size() && k < 6; k++) glog[k] = int'(grant_q[k]);
        chk("rr_grant_count", 32'(grant_q.size()), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("rr_grant%0d", k), 32'(glog[k]), 32'(k % 2));

        // M0 with awvalid and arvalid together: write goes first
        reset_dut();
        sb_q.push_back('{1'b1, 32'h4600_0300, 32'hCAFE_F00D});
        sb_q.push_back('{1'b0, 32'h4600_0304, 32'h0});
        fork
            do_write(1'b0, 32'h4600_0300, 32'hCAFE_F00D, 1'b0, rs0);
            do_read(1'b0, 32'h4600_0304, rd1, rs1);
        join
        chk("wr_rd_bresp", 32'(rs0), 0);
        chk("wr_rd_rdata", rd1, 32'h4600_0304 ^ RD_XOR);
        chk("wr_rd_sb_drained", 32'(sb_q.size()), 0);
        chk("never_aw_and_ar", 32'(both_cnt), 0);

        // wvalid two cycles ahead of awvalid
        reset_dut();
        b10 = b1_cnt;
        aw0 = aw_cnt;
        wc0 = wr_done_cnt;
        sb_q.push_back('{1'b1, 32'h4600_0400, 32'h0BAD_F00D});
        do_write(1'b0, 32'h4600_0400, 32'h0BAD_F00D, 1'b1, rs);
        chk("wlead_bresp", 32'(rs), 0);
        chk("wlead_one_aw", 32'(aw_cnt - aw0), 1);
        chk("wlead_one_write", 32'(wr_done_cnt - wc0), 1);
        chk("wlead_no_m1_bvalid", 32'(b1_cnt - b10), 0);

        // Reset while the write data is still pending downstream
        reset_dut();
        dm_wready    = 1'b0;
        awaddr_a[0]  = 32'h4600_0200;
        wdata_a[0]   = 32'h7777_0000;
        s_awvalid[0] = 1'b1;
        s_wvalid[0]  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_awvalid[0] = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 1);
        chk("midrst_aw_masked", 32'(dm_awvalid), 0);
        chk("midrst_w_pending", 32'(dm_wvalid), 1);
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        s_wvalid[0] = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_m_valids", 32'({dm_awvalid, dm_wvalid, dm_arvalid}), 0);
        chk("midrst_s_readys", 32'({s_awready, s_wready, s_arready}), 0);
        dm_wready = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after the aborted write
        sb_q.push_back('{1'b0, 32'h4600_0200, 32'h0});
        do_read(1'b1, 32'h4600_0200, rd, rs);
        chk("recover_rdata", rd, 32'h4600_0200 ^ RD_XOR);
        chk("final_sb_empty", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
